mux8_1_rr: RTL

//   8:1 round-robin time-division multiplexer; the gathering end of the 1:8 demux path.

---
 rtl/mux8_1_rr.sv | 116 +++++++++++
 1 files changed

// File: rtl/mux8_1_rr.sv
// 8:1 round-robin, packet-aware merge of eight valid/ready lanes onto one registered stream.
// out_sel tags each beat with its source lane so a downstream 1:8 demux can route it back.
module mux8_1_rr #(
  parameter int unsigned WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           in_valid,
  input  logic [8*WIDTH-1:0]   in_data,
  input  logic [7:0]           in_last,
  output logic [7:0]           in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [2:0]           out_sel,
  output logic                 out_last,
  input  logic                 out_ready
);

  localparam int unsigned LANES = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic {ARB, XFER} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [SEL_W-1:0]   ptr;
  logic [SEL_W-1:0]   lock;
  logic [SEL_W-1:0]   grant;
  logic               found;
  logic [SEL_W-1:0]   src_idx;
  logic [WIDTH-1:0]   src_data;
  logic               accept;
  logic               load_en;

  assign load_en = ~out_valid | out_ready;

  // First valid lane searching from ptr upwards, modulo 8
  always_comb begin
    found = 1'b0;
    grant = '0;
    for (int k = 0; k < LANES; k++) begin
      logic [SEL_W-1:0] idx;
      idx = SEL_W'(ptr + SEL_W'(k));
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ARB:  if (load_en && found && !in_last[grant]) state_nxt = XFER;
      XFER: if (load_en && in_valid[lock] && in_last[lock]) state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  // Output decode: one-hot in_ready, gated off during reset and while the output is stalled
  always_comb begin
    in_ready = '0;
    if (!rst) begin
      case (state)
        ARB:     if (load_en && found) in_ready[grant] = 1'b1;
        XFER:    in_ready[lock] = load_en;
        default: in_ready = '0;
      endcase
    end
    src_idx = (state == XFER) ? lock : grant;
    accept  = |(in_valid & in_ready);
  end

  always_comb begin
    src_data = '0;
    for (int l = 0; l < LANES; l++) begin
      if (SEL_W'(l) == src_idx) src_data = in_data[l*WIDTH +: WIDTH];
    end
  end

  // Round-robin pointer and packet lock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr  <= '0;
      lock <= '0;
    end else if (state == ARB && accept) begin
      ptr <= SEL_W'(grant + SEL_W'(1));
      if (!in_last[grant]) lock <= grant;
    end
  end

  // Output register refills in the same cycle it drains
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      out_last  <= 1'b0;
    end else if (load_en) begin
      out_valid <= accept;
      if (accept) begin
        out_data <= src_data;
        out_sel  <= src_idx;
        out_last <= in_last[src_idx];
      end
    end
  end

endmodule
